// File: rtl/mem_stage_dmem_if_if.sv
// Data-memory bus bundle between the MEM stage (master) and the data memory (slave).
// Doubleword bus: one request carries an aligned address, byte enables and 64-bit data.
interface mem_stage_dmem_if_if #(
   parameter int ADDR_W = 32
);
   logic              dmem_req_o;
   logic              dmem_we_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [7:0]        dmem_be_o;
   logic [63:0]       dmem_wdata_o;
   logic              dmem_ack_i;
   logic [63:0]       dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_stage_dmem_if.sv
// MEM-stage data-memory interface: turns an EX/MEM load/store into one req/ack bus
// transaction, shifts store data into its byte lanes, aligns and extends load data,
// and stalls the pipeline until the access has completed, faulted or timed out.
module mem_stage_dmem_if #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 memread_i,
   input  logic                 memwrite_i,
   input  logic [2:0]           funct3_i,
   input  logic [63:0]          addr_i,
   input  logic [63:0]          wdata_i,
   mem_stage_dmem_if_if.master  bus,
   output logic                 mem_stall_o,
   output logic [63:0]          load_data_o,
   output logic                 load_valid_o,
   output logic                 misalign_o,
   output logic                 bus_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       f3_q;
   logic [2:0]       off_q;
   logic             is_load_q;

   logic             acc;
   logic [2:0]       off;
   logic             illegal;
   logic             misaligned;
   logic [7:0]       be_base;
   logic [63:0]      rdata_sh;
   logic [63:0]      load_ext;

   assign acc = memread_i | memwrite_i;
   assign off = addr_i[2:0];

   // Stall while an access waits in IDLE or is on the bus; the pipeline advances in RESP/ERR.
   assign mem_stall_o = rst_ni & (((state_q == S_IDLE) & acc) | (state_q == S_REQ));

   // Decode legality, alignment and the unshifted byte-enable mask of the incoming access.
   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      misaligned = 1'b0;
      be_base    = 8'h01;
      // Unsigned variants only exist for loads; memwrite wins when both strobes are set.
      illegal    = (funct3_i == 3'd7) | (memwrite_i & funct3_i[2]);
      case (funct3_i[1:0])
         2'd1: begin misaligned = off[0];      be_base = 8'h03; end
         2'd2: begin misaligned = |off[1:0];   be_base = 8'h0F; end
         2'd3: begin misaligned = |off;        be_base = 8'hFF; end
         default: begin misaligned = 1'b0;     be_base = 8'h01; end
      endcase
   end

   // Move the addressed bytes down to bit 0, then truncate and extend by access type.
   always_comb begin
      rdata_sh = bus.dmem_rdata_i >> {off_q, 3'b000};
      load_ext = rdata_sh;
      case (f3_q)
         3'd0:    load_ext = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
         3'd1:    load_ext = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
         3'd2:    load_ext = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
         3'd4:    load_ext = {56'd0, rdata_sh[7:0]};
         3'd5:    load_ext = {48'd0, rdata_sh[15:0]};
         3'd6:    load_ext = {32'd0, rdata_sh[31:0]};
         default: load_ext = rdata_sh;
      endcase
   end

   // Access FSM: bus fields are latched on leaving IDLE and held constant while requesting.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         f3_q             <= '0;
         off_q            <= '0;
         is_load_q        <= 1'b0;
         bus.dmem_req_o   <= 1'b0;
         bus.dmem_we_o    <= 1'b0;
         bus.dmem_addr_o  <= '0;
         bus.dmem_be_o    <= '0;
         bus.dmem_wdata_o <= '0;
         load_data_o      <= '0;
         load_valid_o     <= 1'b0;
         misalign_o       <= 1'b0;
         bus_err_o        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
         load_valid_o <= 1'b0;
         misalign_o   <= 1'b0;
         bus_err_o    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (acc) begin
                  if (illegal | misaligned) begin
                     state_q    <= S_ERR;
                     misalign_o <= 1'b1;
                  end else begin
                     state_q          <= S_REQ;
                     cnt_q            <= '0;
                     f3_q             <= funct3_i;
                     off_q            <= off;
                     is_load_q        <= ~memwrite_i;
                     bus.dmem_req_o   <= 1'b1;
                     bus.dmem_we_o    <= memwrite_i;
                     bus.dmem_addr_o  <= {addr_i[ADDR_W-1:3], 3'b000};
                     bus.dmem_be_o    <= be_base << off;
                     bus.dmem_wdata_o <= wdata_i << {off, 3'b000};
                  end
               end
            end
            S_REQ: begin
               if (bus.dmem_ack_i) begin
                  state_q        <= S_RESP;
                  cnt_q          <= '0;
                  bus.dmem_req_o <= 1'b0;
                  load_valid_o   <= is_load_q;
                  if (is_load_q) begin
                     load_data_o <= load_ext;
                  end
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q        <= S_RESP;
                  cnt_q          <= '0;
                  bus.dmem_req_o <= 1'b0;
                  bus_err_o      <= 1'b1;
                  load_valid_o   <= is_load_q;
                  load_data_o    <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            // Inputs are ignored here so the still-held instruction is not issued twice.
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_dmem_if.sv
// Self-checking bench for mem_stage_dmem_if: directed cases plus randomized accesses
// compared against an arithmetic model of byte lanes, alignment and extension.
module tb_mem_stage_dmem_if;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        memread_i = 1'b0;
   logic        memwrite_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [63:0] addr_i = '0;
   logic [63:0] wdata_i = '0;
   logic        mem_stall_o;
   logic [63:0] load_data_o;
   logic        load_valid_o;
   logic        misalign_o;
   logic        bus_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage_dmem_if_if #(.ADDR_W(ADDR_W)) bus ();

   mem_stage_dmem_if #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .memread_i    (memread_i),
      .memwrite_i   (memwrite_i),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .bus          (bus.master),
      .mem_stall_o  (mem_stall_o),
      .load_data_o  (load_data_o),
      .load_valid_o (load_valid_o),
      .misalign_o   (misalign_o),
      .bus_err_o    (bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Access size in bytes from funct3.
   function automatic int size_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_legal(input logic mw, input logic [2:0] f3, input logic [63:0] a);
      int n;
      n = size_bytes(f3);
      if (f3 == 3'd7) return 1'b0;
      if (mw && f3 >= 3'd4) return 1'b0;
      return (int'(a[2:0]) % n) == 0;
   endfunction

   function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] rd);
      int          n;
      logic [63:0] mask;
      logic [63:0] v;
      n    = size_bytes(f3);
      mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
      v    = (rd >> (8 * int'(a[2:0]))) & mask;
      if (f3 < 3'd3 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // Drive one access and follow it to completion. ack_lat = REQ cycle index of the ack,
   // negative means never. hold_resp keeps the instruction and an ack asserted during RESP.
   task automatic run_access(input logic mr, input logic mw, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                             input int ack_lat, input bit hold_resp, input string name);
      bit                legal;
      bit                is_load;
      bit                timed_out;
      bit                done;
      int                req_cycles;
      int                exp_req;
      int                bev;
      logic [ADDR_W-1:0] exp_addr;
      logic [7:0]        exp_be;
      logic [63:0]       exp_wd;
      logic [63:0]       exp_ld;
      legal      = model_legal(mw, f3, a);
      is_load    = !mw && mr;
      timed_out  = (ack_lat < 0) || (ack_lat >= TIMEOUT);
      exp_req    = timed_out ? TIMEOUT : ack_lat + 1;
      bev        = ((1 << size_bytes(f3)) - 1) << int'(a[2:0]);
      exp_be     = bev[7:0];
      exp_addr   = ADDR_W'(a) & ~ADDR_W'(7);
      exp_wd     = wd << (8 * int'(a[2:0]));
      exp_ld     = timed_out ? 64'd0 : model_load(f3, a, rd);
      req_cycles = 0;
      done       = 1'b0;

      @(negedge clk_i);
      memread_i = mr; memwrite_i = mw; funct3_i = f3; addr_i = a; wdata_i = wd;
      bus.dmem_ack_i = 1'b0;
      #1;
      n_checks++;
      if (mem_stall_o !== 1'b1) begin
         n_fail++; $display("FAIL %s idle_stall: got %b want 1", name, mem_stall_o);
      end
      @(posedge clk_i); #1;

      if (!legal) begin
         n_checks++;
         if ({misalign_o, bus.dmem_req_o, mem_stall_o, load_valid_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s err_cycle: got mis/req/stall/lv=%b want 1000", name,
                     {misalign_o, bus.dmem_req_o, mem_stall_o, load_valid_o});
         end
      end else begin
         for (int c = 0; c < TIMEOUT + 2 && !done; c++) begin
            if (bus.dmem_req_o === 1'b1) begin
               req_cycles++;
               n_checks++;
               if ({mem_stall_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o}
                   !== {1'b1, mw, exp_addr, exp_be, exp_wd}) begin
                  n_fail++;
                  $display("FAIL %s req_fields: got stall=%b we=%b addr=%h be=%h wd=%h want 1 %b %h %h %h",
                           name, mem_stall_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o,
                           bus.dmem_wdata_o, mw, exp_addr, exp_be, exp_wd);
               end
               if (c == ack_lat) begin
                  bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = rd;
               end
               @(posedge clk_i); #1;
               bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = {$urandom, $urandom};
            end else begin
               done = 1'b1;
            end
         end
         n_checks++;
         if (req_cycles != exp_req) begin
            n_fail++; $display("FAIL %s req_cycles: got %0d want %0d", name, req_cycles, exp_req);
         end
         n_checks++;
         if ({mem_stall_o, load_valid_o, bus_err_o, misalign_o} !== {1'b0, is_load, timed_out, 1'b0}) begin
            n_fail++;
            $display("FAIL %s resp_flags: got stall/lv/err/mis=%b want %b", name,
                     {mem_stall_o, load_valid_o, bus_err_o, misalign_o},
                     {1'b0, is_load, timed_out, 1'b0});
         end
         if (is_load) begin
            n_checks++;
            if (load_data_o !== exp_ld) begin
               n_fail++; $display("FAIL %s load_data: got %h want %h", name, load_data_o, exp_ld);
            end
         end
      end

      // RESP/ERR cycle: the pipeline advances; optionally keep the old instruction and an ack up.
      if (hold_resp) begin
         bus.dmem_ack_i = 1'b1;
      end else begin
         memread_i = 1'b0; memwrite_i = 1'b0;
      end
      @(posedge clk_i); #1;
      n_checks++;
      if ({bus.dmem_req_o, load_valid_o, misalign_o, bus_err_o, mem_stall_o} !== {4'b0000, hold_resp}) begin
         n_fail++;
         $display("FAIL %s back_in_idle: got req/lv/mis/err/stall=%b want %b", name,
                  {bus.dmem_req_o, load_valid_o, misalign_o, bus_err_o, mem_stall_o},
                  {4'b0000, hold_resp});
      end
      memread_i = 1'b0; memwrite_i = 1'b0; bus.dmem_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      memread_i = 1'b1; funct3_i = 3'd3; bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = '1;
      #12;
      n_checks++;
      if ({bus.dmem_req_o, bus.dmem_we_o, bus.dmem_be_o, mem_stall_o, load_valid_o,
           misalign_o, bus_err_o, load_data_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got req=%b be=%h stall=%b lv=%b mis=%b err=%b ld=%h want all 0",
                  bus.dmem_req_o, bus.dmem_be_o, mem_stall_o, load_valid_o, misalign_o, bus_err_o,
                  load_data_o);
      end
      @(negedge clk_i);
      memread_i = 1'b0; rst_ni = 1'b1;
      // Idle cycles with a stray ack must produce nothing.
      repeat (3) begin
         @(posedge clk_i); #1;
         n_checks++;
         if ({bus.dmem_req_o, mem_stall_o, load_valid_o, misalign_o, bus_err_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: got req/stall/lv/mis/err=%b want 00000",
                     {bus.dmem_req_o, mem_stall_o, load_valid_o, misalign_o, bus_err_o});
         end
      end
      bus.dmem_ack_i = 1'b0;
   endtask

   task automatic test_directed();
      run_access(1, 0, 3'd3, 64'h100, 64'h0, 64'h1122334455667788, 0, 0, "ld_0x100");
      run_access(1, 0, 3'd0, 64'h107, 64'h0, 64'h80123456789ABCDE, 1, 0, "lb_0x107");
      run_access(1, 0, 3'd4, 64'h107, 64'h0, 64'h80123456789ABCDE, 2, 0, "lbu_0x107");
      run_access(0, 1, 3'd1, 64'h202, 64'hABCD, 64'h0, 0, 0, "sh_0x202");
      run_access(1, 1, 3'd2, 64'h304, 64'hDEADBEEF, 64'h0, 0, 0, "both_strobes_store");
      run_access(1, 0, 3'd5, 64'h40A, 64'h0, 64'hFEDC_BA98_8765_4321, 0, 0, "lhu");
      run_access(1, 0, 3'd2, 64'h40C, 64'h0, 64'h8765_4321_0000_0000, 0, 0, "lw_neg");
   endtask

   task automatic test_misalign();
      run_access(1, 0, 3'd2, 64'h101, 64'h0, 64'h0, 0, 0, "lw_0x101");
      run_access(1, 0, 3'd1, 64'h103, 64'h0, 64'h0, 0, 0, "lh_odd");
      run_access(0, 1, 3'd3, 64'h104, 64'h0, 64'h0, 0, 0, "sd_0x104");
      run_access(1, 0, 3'd7, 64'h100, 64'h0, 64'h0, 0, 0, "funct3_7");
      run_access(0, 1, 3'd4, 64'h100, 64'h0, 64'h0, 0, 0, "store_unsigned");
   endtask

   task automatic test_timeout();
      run_access(1, 0, 3'd3, 64'h100, 64'h0, 64'hFFFF, -1, 0, "ld_timeout");
      run_access(1, 0, 3'd3, 64'h108, 64'h0, 64'h1234, TIMEOUT - 1, 0, "ld_last_cycle_ack");
   endtask

   task automatic test_reset_in_req();
      @(negedge clk_i);
      memread_i = 1'b1; funct3_i = 3'd3; addr_i = 64'h500;
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.dmem_req_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_in_req_pre: got req=%b want 1", bus.dmem_req_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if ({bus.dmem_req_o, mem_stall_o} !== 2'b00) begin
         n_fail++; $display("FAIL rst_in_req_drop: got req/stall=%b want 00", {bus.dmem_req_o, mem_stall_o});
      end
      @(negedge clk_i);
      memread_i = 1'b0; rst_ni = 1'b1; bus.dmem_ack_i = 1'b1;
      @(posedge clk_i); #1;
      n_checks++;
      if ({bus.dmem_req_o, mem_stall_o, load_valid_o, bus_err_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_ack_ignored: got req/stall/lv/err=%b want 0000",
                  {bus.dmem_req_o, mem_stall_o, load_valid_o, bus_err_o});
      end
      bus.dmem_ack_i = 1'b0;
      run_access(1, 0, 3'd3, 64'h500, 64'h0, 64'hCAFE, 0, 0, "after_reset_ld");
   endtask

   task automatic test_back_to_back();
      run_access(1, 0, 3'd3, 64'h600, 64'h0, 64'h0123456789ABCDEF, 0, 1, "hold_in_resp_ld");
      run_access(0, 1, 3'd0, 64'h605, 64'h77, 64'h0, 0, 1, "hold_in_resp_sb");
      run_access(1, 0, 3'd2, 64'h602, 64'h0, 64'h0, 0, 1, "hold_in_err");
   endtask

   task automatic test_random();
      logic [1:0]  sel;
      logic [63:0] a;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         sel = 2'($urandom_range(1, 3));
         a   = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
         lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
         run_access(sel[0], sel[1], 3'($urandom_range(0, 7)), a, {$urandom, $urandom},
                    {$urandom, $urandom}, lat, bit'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      bus.dmem_ack_i   = 1'b0;
      bus.dmem_rdata_i = '0;
      test_reset();
      test_directed();
      test_misalign();
      test_timeout();
      test_reset_in_req();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
